// File: rtl/ahb_slave_posted.sv
// AHB-Lite slave bridge to the native valid/ready request port. Writes are
// posted through a small FIFO; reads wait for the FIFO to drain before issuing.
module ahb_slave_posted #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    WFIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter longint unsigned       WINDOW_SIZE = 'h1000
) (
  input  logic                            i_clk_ahb,
  input  logic                            i_rst_ahb,
  input  logic                            i_hselx,
  input  logic                            i_hready,
  input  logic [1:0]                      i_htrans,
  input  logic [2:0]                      i_hsize,
  input  logic                            i_hwrite,
  input  logic [ADDR_WIDTH-1:0]           i_haddr,
  input  logic [DATA_WIDTH-1:0]           i_hwdata,
  output logic                            o_hreadyout,
  output logic                            o_hresp,
  output logic [DATA_WIDTH-1:0]           o_hrdata,
  output logic                            o_valid,
  output logic                            o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]           o_addr,
  output logic [DATA_WIDTH-1:0]           o_wr_data,
  output logic [DATA_WIDTH/8-1:0]         o_wr_strb,
  input  logic                            i_ready,
  input  logic                            i_rd_valid,
  input  logic [DATA_WIDTH-1:0]           i_rd_data,
  output logic [$clog2(WFIFO_DEPTH):0]    o_wfifo_level,
  output logic [2:0]                      o_dbg_state
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LG = $clog2(NB);
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_SZ = (ADDR_WIDTH+1)'(WINDOW_SIZE);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WDATA    = 3'd1;
  localparam logic [2:0] S_RD_DRAIN = 3'd2;
  localparam logic [2:0] S_RD_REQ   = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_RD_DONE  = 3'd5;
  localparam logic [2:0] S_ERR1     = 3'd6;
  localparam logic [2:0] S_ERR2     = 3'd7;

  logic [2:0]            state, state_n;
  logic                  accept, eval_new, xfer_err, addr_err, size_err, align_err;
  logic [2:0]            align_mask;
  logic [ADDR_WIDTH:0]   win_off;
  logic [NB-1:0]         strb_calc;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [NB-1:0]         lat_strb;

  logic [ADDR_WIDTH-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WFIFO_DEPTH];
  logic [NB-1:0]         fifo_strb [WFIFO_DEPTH];
  logic [PW:0]           wptr, rptr, wptr_n, rptr_n;
  logic                  empty, full, push, pop, empty_n;

  // Transfer decode and error classification for the current address phase.
  assign accept   = i_hselx && i_hready && (i_htrans == 2'b10 || i_htrans == 2'b11);
  assign win_off  = {1'b0, i_haddr} - WIN_LO;
  assign addr_err = (win_off >= WIN_SZ);
  assign size_err = (i_hsize > 3'(LG));

  always_comb begin
    case (i_hsize)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign align_err = |(align_mask & i_haddr[2:0]);
  assign xfer_err  = addr_err || size_err || align_err;

  always_comb begin
    int off;
    strb_calc = '0;
    off = int'(i_haddr[LG-1:0]);
    for (int b = 0; b < NB; b++)
      if (b >= off && b < off + (1 << i_hsize)) strb_calc[b] = 1'b1;
  end

  // FIFO pointers carry an extra MSB so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign pop     = !empty && i_ready;
  assign push    = (state == S_WDATA) && (!full || pop);
  assign wptr_n  = wptr + {{PW{1'b0}}, push};
  assign rptr_n  = rptr + {{PW{1'b0}}, pop};
  assign empty_n = (wptr_n == rptr_n);

  always_comb begin
    state_n  = state;
    eval_new = 1'b0;
    case (state)
      S_IDLE, S_RD_DONE, S_ERR2: eval_new = 1'b1;
      S_WDATA:    if (push) eval_new = 1'b1;
      S_RD_DRAIN: if (empty_n) state_n = S_RD_REQ;
      S_RD_REQ:   if (i_ready) state_n = S_RD_WAIT;
      S_RD_WAIT:  if (i_rd_valid) state_n = S_RD_DONE;
      S_ERR1:     state_n = S_ERR2;
      default:    state_n = S_IDLE;
    endcase
    if (eval_new) begin
      state_n = S_IDLE;
      if (accept) begin
        if (xfer_err)      state_n = S_ERR1;
        else if (i_hwrite) state_n = S_WDATA;
        else               state_n = empty_n ? S_RD_REQ : S_RD_DRAIN;
      end
    end
  end

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      lat_addr <= '0;
      lat_strb <= '0;
      o_hrdata <= '0;
    end else begin
      state <= state_n;
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      if (eval_new && accept && !xfer_err) begin
        lat_addr <= i_haddr;
        lat_strb <= strb_calc;
      end
      if (state == S_RD_WAIT && i_rd_valid) o_hrdata <= i_rd_data;
    end
  end

  always_ff @(posedge i_clk_ahb) begin
    if (push) begin
      fifo_addr[wptr[PW-1:0]] <= lat_addr;
      fifo_data[wptr[PW-1:0]] <= i_hwdata;
      fifo_strb[wptr[PW-1:0]] <= lat_strb;
    end
  end

  always_comb begin
    o_hreadyout = 1'b1;
    case (state)
      S_WDATA:                                  o_hreadyout = !full || pop;
      S_RD_DRAIN, S_RD_REQ, S_RD_WAIT, S_ERR1:  o_hreadyout = 1'b0;
      default:                                  o_hreadyout = 1'b1;
    endcase
  end

  assign o_hresp       = (state == S_ERR1) || (state == S_ERR2);
  assign o_wfifo_level = wptr - rptr;
  assign o_dbg_state   = state;

  // Native port: a request transfers on a cycle where o_valid && i_ready; while
  // o_valid is high and i_ready low every request field is held stable.
  always_comb begin
    o_valid   = 1'b0;
    o_rd0_wr1 = 1'b0;
    o_addr    = '0;
    o_wr_data = '0;
    o_wr_strb = '0;
    if (!empty) begin
      o_valid   = 1'b1;
      o_rd0_wr1 = 1'b1;
      o_addr    = fifo_addr[rptr[PW-1:0]];
      o_wr_data = fifo_data[rptr[PW-1:0]];
      o_wr_strb = fifo_strb[rptr[PW-1:0]];
    end else if (state == S_RD_REQ) begin
      o_valid = 1'b1;
      o_addr  = lat_addr;
    end
  end
endmodule
